reg_mux_2to1: RTL and testbench

Registered, parameterised 2-to-1 multiplexer for the CORDIC datapath. It selects between two signed operands, for example the rotated or unrotated X/Y/Z value of an iteration stage. The result is captured in an output register, so stage boundaries stay timing-clean. Instances sit between CORDIC iteration stages and at the angle/quadrant pre-rotation step.

---
 rtl/reg_mux_2to1_pkg.sv | 7 +
 rtl/reg_mux_2to1.sv | 51 +++++
 tb/tb_reg_mux_2to1.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/reg_mux_2to1_pkg.sv
// Shared CORDIC datapath constants. Instances of reg_mux_2to1 pass
// CORDIC_WIDTH to BIT_WIDTH; the mux itself does not import this package.
package reg_mux_2to1_pkg;

    localparam int CORDIC_WIDTH = 16;

endpackage : reg_mux_2to1_pkg

// File: rtl/reg_mux_2to1.sv
// Registered 2-to-1 select between two signed operands, with a qualifying
// valid flag. One clock of latency, full throughput, load gated by en_in.
module reg_mux_2to1 #(
    parameter int                   BIT_WIDTH   = 8,
    parameter logic [BIT_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [BIT_WIDTH-1:0] d0_in,
    input  logic signed [BIT_WIDTH-1:0] d1_in,
    input  logic                        sel_in,
    input  logic                        en_in,
    input  logic                        valid_in,
    output logic signed [BIT_WIDTH-1:0] y_output,
    output logic                        valid_out
);

    logic signed [BIT_WIDTH-1:0] y_next;

    // An if on an unknown condition takes the else branch, so X/Z on sel_in
    // selects d0_in instead of smearing X into the register.
    always_comb begin
        y_next = d0_in;
        if (sel_in == 1'b1) begin
            y_next = d1_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_output  <= RESET_VALUE;
            valid_out <= 1'b0;
        end else if (en_in) begin
            y_output  <= y_next;
            valid_out <= valid_in;
        end
    end

`ifndef SYNTHESIS
    sel_known_chk: assert property (
        @(posedge clk) disable iff (!rst_n)
        (en_in && valid_in) |-> !$isunknown(sel_in)
    ) else $error("reg_mux_2to1: unknown sel_in on a valid enabled sample");

    hold_chk: assert property (
        @(posedge clk) disable iff (!rst_n)
        !en_in |=> ($stable(y_output) && $stable(valid_out))
    ) else $error("reg_mux_2to1: registers changed while en_in was low");
`endif

endmodule : reg_mux_2to1

// File: tb/tb_reg_mux_2to1.sv
// Directed-vector bench for reg_mux_2to1: an 8-bit default instance and a
// CORDIC-width instance share clock, reset and control.
module tb_reg_mux_2to1;
    import reg_mux_2to1_pkg::*;

    logic clk;
    logic rst_n;
    logic sel_in, en_in, valid_in;
    logic signed [7:0] d0_in, d1_in, y_output;
    logic valid_out;
    logic signed [CORDIC_WIDTH-1:0] d0_w, d1_w, y_w;
    logic valid_w;

    int n_checks = 0;
    int n_bad    = 0;

    reg_mux_2to1 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d0_in    (d0_in),
        .d1_in    (d1_in),
        .sel_in   (sel_in),
        .en_in    (en_in),
        .valid_in (valid_in),
        .y_output (y_output),
        .valid_out(valid_out)
    );

    reg_mux_2to1 #(.BIT_WIDTH(CORDIC_WIDTH)) dut_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .d0_in    (d0_w),
        .d1_in    (d1_w),
        .sel_in   (sel_in),
        .en_in    (en_in),
        .valid_in (valid_in),
        .y_output (y_w),
        .valid_out(valid_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance past the next rising edge and settle before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        en_in    = 1'b0;
        valid_in = 1'b0;
        sel_in   = 1'b0;
        d0_in    = '0;
        d1_in    = '0;
        d0_w     = '0;
        d1_w     = '0;
        #3;
        check("reset_y",     {24'd0, y_output}, 32'h0);
        check("reset_valid", {31'd0, valid_out}, 32'h0);

        // Reset holds even with en_in high across an edge.
        en_in = 1'b1; valid_in = 1'b1; d0_in = 8'sd30; d1_in = 8'sd45;
        tick();
        check("reset_hold_y",     {24'd0, y_output}, 32'h0);
        check("reset_hold_valid", {31'd0, valid_out}, 32'h0);

        rst_n = 1'b1;
        tick();
        check("sel0_y",     {24'd0, y_output}, 32'd30);
        check("sel0_valid", {31'd0, valid_out}, 32'h1);
        sel_in = 1'b1;
        tick();
        check("sel1_y", {24'd0, y_output}, 32'd45);

        // Changes between edges must not reach the output.
        d1_in = 8'sd99;
        #3;
        check("mid_cycle_y", {24'd0, y_output}, 32'd45);

        // Signed extremes, alternating select.
        d0_in = -8'sd128; d1_in = 8'sd127;
        for (int i = 0; i < 4; i++) begin
            sel_in = i[0];
            tick();
            check($sformatf("signed_alt%0d", i), {24'd0, y_output}, i[0] ? 32'h7F : 32'h80);
        end

        // Enable hold with valid_out high.
        d1_in = 8'sd45; sel_in = 1'b1;
        tick();
        check("load45_y", {24'd0, y_output}, 32'd45);
        en_in = 1'b0; d0_in = 8'sd10; d1_in = 8'sd20;
        for (int i = 0; i < 3; i++) begin
            sel_in = ~sel_in;
            tick();
            check($sformatf("hold_y%0d", i),     {24'd0, y_output}, 32'd45);
            check($sformatf("hold_valid%0d", i), {31'd0, valid_out}, 32'h1);
        end

        // Enable hold with valid_out low: valid_in rising must not leak through.
        en_in = 1'b1; valid_in = 1'b0;
        tick();
        check("vin0_valid", {31'd0, valid_out}, 32'h0);
        en_in = 1'b0; valid_in = 1'b1;
        tick();
        check("hold_valid_low", {31'd0, valid_out}, 32'h0);

        // Async reset between edges.
        en_in = 1'b1; d1_in = 8'sd45; sel_in = 1'b1;
        tick();
        check("pre_reset_y", {24'd0, y_output}, 32'd45);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_y",     {24'd0, y_output}, 32'h0);
        check("async_reset_valid", {31'd0, valid_out}, 32'h0);
        tick();
        rst_n = 1'b1; d0_in = 8'sd30; sel_in = 1'b0;
        tick();
        check("post_reset_y",     {24'd0, y_output}, 32'd30);
        check("post_reset_valid", {31'd0, valid_out}, 32'h1);

        // Wide instance, no truncation.
        d1_w = -16'sd1000; sel_in = 1'b1;
        tick();
        check("wide_y", {16'd0, y_w}, 32'h0000FC18);
        check("wide_valid", {31'd0, valid_w}, 32'h1);

        // Valid pipeline 1,0,1,1.
        sel_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_in = (i != 1);
            tick();
            check($sformatf("valid_pipe%0d", i), {31'd0, valid_out}, (i != 1) ? 32'h1 : 32'h0);
        end

        // Unknown select on an invalid sample falls back to d0_in.
        valid_in = 1'b0; sel_in = 1'bx; d0_in = 8'sd7; d1_in = 8'sd9;
        tick();
        check("sel_x_y", {24'd0, y_output}, 32'd7);
        sel_in = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_reg_mux_2to1
